// File: rtl/spi_rr_scheduler_if.sv
// Host-side handshake between per-channel requesters and the shared SPI engine.
// master = requester side, slave = scheduler side.
interface spi_rr_scheduler_if #(
  parameter int WIDTH = 16
);
  logic [3:0]         req;
  logic [4*WIDTH-1:0] tx_data;
  logic [3:0]         ack;
  logic [WIDTH-1:0]   rx_data;
  logic [1:0]         rx_ch;
  logic               rx_valid;
  logic               busy;

  modport master (output req, tx_data, input ack, rx_data, rx_ch, rx_valid, busy);
  modport slave  (input req, tx_data, output ack, rx_data, rx_ch, rx_valid, busy);
endinterface

// File: rtl/spi_rr_scheduler.sv
// Round-robin arbiter feeding one mode-0, MSB-first SPI shift engine that is
// steered onto one of four channel pin sets at a time.
module spi_rr_scheduler #(
  parameter int WIDTH   = 16,
  parameter int CLK_DIV = 4
) (
  input  logic                 clk,
  input  logic                 rstn,
  spi_rr_scheduler_if.slave    bus,
  output logic [3:0]           SCLK,
  output logic [3:0]           MOSI,
  input  logic [3:0]           MISO,
  output logic [3:0]           CS_n
);
  localparam int BW = $clog2(WIDTH + 1);
  localparam int DW = $clog2(CLK_DIV + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
  localparam logic [DW-1:0] DIV_END  = DW'(CLK_DIV - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD, GAP} state_t;

  state_t           state;
  logic [1:0]       ptr, ch;
  logic [WIDTH-1:0] sr;
  logic [BW-1:0]    bcnt;
  logic [DW-1:0]    div;

  logic             gnt_vld;
  logic [1:0]       gnt, idx;
  logic [WIDTH-1:0] tx_sel;
  logic             div_end, arb;

  // Scan ptr+1..ptr+4; k=4 wraps to ptr itself, so the last winner is lowest priority.
  always_comb begin
    gnt_vld = 1'b0;
    gnt     = ptr;
    idx     = ptr;
    for (int k = 1; k <= 4; k++) begin
      idx = ptr + 2'(k);
      if (!gnt_vld && bus.req[idx]) begin
        gnt_vld = 1'b1;
        gnt     = idx;
      end
    end
    tx_sel = bus.tx_data[32'(gnt)*WIDTH +: WIDTH];
  end

  assign div_end = (div == DIV_END);
  // The last GAP cycle doubles as the arbitration slot so back-to-back grants
  // land exactly CLK_DIV cycles after CS_n rises.
  assign arb     = (state == IDLE) || (state == GAP && div_end);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= IDLE;
      ptr          <= 2'd3;
      ch           <= 2'd0;
      sr           <= '0;
      bcnt         <= '0;
      div          <= '0;
      bus.ack      <= '0;
      bus.rx_data  <= '0;
      bus.rx_ch    <= '0;
      bus.rx_valid <= 1'b0;
      bus.busy     <= 1'b0;
      SCLK         <= '0;
      MOSI         <= '0;
      CS_n         <= 4'hF;
    end else begin
      bus.ack      <= '0;
      bus.rx_valid <= 1'b0;
      if (arb) begin
        div  <= '0;
        bcnt <= '0;
        if (gnt_vld) begin
          ptr        <= gnt;
          ch         <= gnt;
          bus.ack    <= 4'b0001 << gnt;
          sr         <= tx_sel;
          CS_n       <= ~(4'b0001 << gnt);
          MOSI       <= '0;
          MOSI[gnt]  <= tx_sel[WIDTH-1];
          bus.busy   <= 1'b1;
          state      <= SHIFT;
        end else begin
          state <= IDLE;
        end
      end else begin
        case (state)
          GAP: div <= div + 1'b1;
          SHIFT: begin
            if (!div_end) begin
              div <= div + 1'b1;
            end else begin
              div <= '0;
              if (!SCLK[ch]) begin
                // Sampling shifts left; the pending MOSI bit is already registered.
                SCLK[ch] <= 1'b1;
                sr       <= {sr[WIDTH-2:0], MISO[ch]};
              end else begin
                SCLK[ch] <= 1'b0;
                if (bcnt == LAST_BIT) begin
                  bcnt  <= '0;
                  state <= HOLD;
                end else begin
                  MOSI[ch] <= sr[WIDTH-1];
                  bcnt     <= bcnt + 1'b1;
                end
              end
            end
          end
          HOLD: begin
            if (!div_end) begin
              div <= div + 1'b1;
            end else begin
              div          <= '0;
              state        <= GAP;
              CS_n         <= 4'hF;
              MOSI         <= '0;
              bus.busy     <= 1'b0;
              bus.rx_valid <= 1'b1;
              bus.rx_data  <= sr;
              bus.rx_ch    <= ch;
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_spi_rr_scheduler.sv
// Directed bench for spi_rr_scheduler: default instance plus a WIDTH=8,
// CLK_DIV=1 instance with MOSI looped back to MISO.
module tb_spi_rr_scheduler;
  logic       clk, rstn;
  logic [3:0] sclk, mosi, miso, cs_n;
  logic [3:0] sclk2, mosi2, cs_n2;
  int         total = 0, bad = 0, cs_bad = 0;

  spi_rr_scheduler_if #(.WIDTH(16)) b1 ();
  spi_rr_scheduler_if #(.WIDTH(8))  b2 ();

  spi_rr_scheduler #(.WIDTH(16), .CLK_DIV(4)) dut (
    .clk(clk), .rstn(rstn), .bus(b1),
    .SCLK(sclk), .MOSI(mosi), .MISO(miso), .CS_n(cs_n));

  spi_rr_scheduler #(.WIDTH(8), .CLK_DIV(1)) dut2 (
    .clk(clk), .rstn(rstn), .bus(b2),
    .SCLK(sclk2), .MOSI(mosi2), .MISO(mosi2), .CS_n(cs_n2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if ($countones(~cs_n) > 1) cs_bad++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int oh2i(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Waits for the next ack pulse; cyc = edges elapsed, ch = granted channel.
  task automatic wait_ack(input int maxc, output int ch, output int cyc);
    ch  = -1;
    cyc = 0;
    while (cyc < maxc) begin
      tick();
      cyc++;
      if (b1.ack != 4'b0) begin
        ch = oh2i(b1.ack);
        return;
      end
    end
    chk("ack_timeout", 32'(cyc), 32'(maxc + 1));
  endtask

  logic [15:0] rx_word, mosi_w;
  int ch, cyc, n, sclk_ok;

  initial begin
    rstn = 1'b0;
    b1.req = '0; b1.tx_data = '0; miso = '0;
    b2.req = '0; b2.tx_data = '0;
    repeat (2) tick();
    chk("rst_ack",   b1.ack, 0);
    chk("rst_cs",    cs_n, 4'hF);
    chk("rst_sclk",  sclk, 0);
    chk("rst_mosi",  mosi, 0);
    chk("rst_busy",  b1.busy, 0);
    chk("rst_rxv",   b1.rx_valid, 0);
    chk("rst_rxd",   b1.rx_data, 0);
    chk("rst_rxch",  b1.rx_ch, 0);
    chk("rst_cs2",   cs_n2, 4'hF);
    rstn = 1'b1;
    tick();

    // Single transfer on channel 0
    rx_word = 16'h3C5A;
    b1.tx_data[15:0] = 16'hA5C3;
    b1.req = 4'b0001;
    tick();
    b1.req = '0;
    chk("t0_ack",  b1.ack, 4'b0001);
    chk("t0_cs",   cs_n, 4'hE);
    chk("t0_busy", b1.busy, 1);
    chk("t0_mosi", mosi, 4'b0001);
    miso[0] = rx_word[15];
    mosi_w = '0;
    sclk_ok = 0;
    for (int i = 0; i < 16; i++) begin
      repeat (4) tick();
      if (sclk[0] === 1'b1) sclk_ok++;
      mosi_w = {mosi_w[14:0], mosi[0]};
      repeat (4) tick();
      if (i < 15) miso[0] = rx_word[14-i];
    end
    chk("sclk_rises", 32'(sclk_ok), 16);
    chk("mosi_word", mosi_w, 16'hA5C3);
    repeat (3) tick();
    chk("t131_rxv", b1.rx_valid, 0);
    chk("t131_cs",  cs_n, 4'hE);
    tick();
    chk("t132_rxv",  b1.rx_valid, 1);
    chk("t132_rxd",  b1.rx_data, 16'h3C5A);
    chk("t132_rxch", b1.rx_ch, 0);
    chk("t132_cs",   cs_n, 4'hF);
    chk("t132_busy", b1.busy, 0);
    tick();
    chk("rxv_pulse", b1.rx_valid, 0);
    chk("rxd_hold",  b1.rx_data, 16'h3C5A);
    miso = '0;

    // Round-robin from a fresh reset, req held high
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    tick();
    b1.tx_data = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    b1.req = 4'hF;
    wait_ack(5, ch, cyc);
    chk("rr0_ch", 32'(ch), 0);
    for (int k = 1; k <= 4; k++) begin
      wait_ack(200, ch, cyc);
      chk($sformatf("rr%0d_ch", k), 32'(ch), 32'(k % 4));
      chk($sformatf("rr%0d_gap", k), 32'(cyc), 136);
    end
    b1.req = '0;
    repeat (140) tick();

    // Priority follows the pointer
    b1.req = 4'b0100;
    wait_ack(5, ch, cyc);
    chk("pr_first", 32'(ch), 2);
    b1.req = '0;
    repeat (140) tick();
    b1.req = 4'b0101;
    wait_ack(5, ch, cyc);
    chk("pr_ch0", 32'(ch), 0);
    chk("pr_lat", 32'(cyc), 1);
    b1.req = 4'b0100;
    wait_ack(200, ch, cyc);
    chk("pr_ch2", 32'(ch), 2);
    chk("pr_gap", 32'(cyc), 136);
    b1.req = '0;
    repeat (140) tick();

    // Cancel: req[1] raised and dropped while channel 3 is busy
    b1.req = 4'b1000;
    wait_ack(5, ch, cyc);
    chk("cx_ch3", 32'(ch), 3);
    b1.req = '0;
    repeat (50) tick();
    b1.req = 4'b0010;
    repeat (50) tick();
    b1.req = '0;
    n = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (b1.ack != 4'b0) n++;
    end
    chk("cx_noack", 32'(n), 0);
    chk("cx_idle",  b1.busy, 0);

    // Reset mid-transfer on channel 1
    b1.req = 4'b0010;
    wait_ack(5, ch, cyc);
    chk("rm_ch1", 32'(ch), 1);
    b1.req = '0;
    repeat (49) tick();
    chk("rm_active", cs_n, 4'hD);
    #3 rstn = 1'b0;
    #1;
    chk("rm_cs",   cs_n, 4'hF);
    chk("rm_sclk", sclk, 0);
    chk("rm_mosi", mosi, 0);
    chk("rm_busy", b1.busy, 0);
    repeat (3) tick();
    rstn = 1'b1;
    n = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (b1.rx_valid) n++;
    end
    chk("rm_norxv", 32'(n), 0);
    b1.req = 4'b1000;
    wait_ack(5, ch, cyc);
    chk("rm_ch3", 32'(ch), 3);
    b1.req = '0;
    repeat (140) tick();
    b1.req = 4'b1001;
    wait_ack(5, ch, cyc);
    chk("rm_ptr", 32'(ch), 0);
    b1.req = '0;
    repeat (140) tick();

    // WIDTH=8, CLK_DIV=1 with loopback
    b2.tx_data[7:0] = 8'h81;
    b2.req = 4'b0001;
    tick();
    b2.req = '0;
    chk("p2_ack", b2.ack, 4'b0001);
    n = 0;
    while (n < 40 && !b2.rx_valid) begin
      tick();
      n++;
    end
    chk("p2_lat",  32'(n), 17);
    chk("p2_rxd",  b2.rx_data, 8'h81);
    chk("p2_cs",   cs_n2, 4'hF);

    chk("cs_onehot", 32'(cs_bad), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
